// File: rtl/axi_aw_rr_scheduler.sv
// ---------------------------------------------------------------------------
// axi_aw_rr_scheduler
//
// Write-address scheduler for one initiator port of the AXI node. Picks one
// of the N_TARG_PORT slave-port AW requesters round-robin and forwards its
// payload. Every AW handshake also pushes the winner's {BIN_ID, OH_ID} into
// the write-data allocator's ID FIFO. A grant is issued only when the FIFO
// can take the ID and fewer than MAX_OUTSTANDING write bursts are still
// waiting for their B response.
//
// Once awvalid_o has been raised without awready_i, the winner is frozen
// (LOCKED) until the handshake completes, so the initiator sees a stable
// address channel.
//
// Ports
//   clk              clock, rising edge
//   rst_n            synchronous active-low reset
//   awvalid_i        per-port AW valid
//   awpayload_i      per-port packed AW payload
//   awready_o        per-port AW ready, one-hot or zero
//   awvalid_o        AW valid to the initiator port
//   awpayload_o      payload of the selected port
//   awready_i        AW ready from the initiator port
//   push_ID_o        ID FIFO push strobe (AW handshake cycle only)
//   ID_o             {binary index, one-hot index} of the selected port
//   grant_FIFO_ID_i  ID FIFO not full
//   bvalid_i         B valid observed on the initiator port
//   bready_i         B ready observed on the initiator port
//   outstanding_o    write bursts accepted but not yet answered
// ---------------------------------------------------------------------------
module axi_aw_rr_scheduler #(
    parameter int N_TARG_PORT     = 7,
    parameter int LOG_N_TARG      = $clog2(N_TARG_PORT),
    parameter int AW_PAYLOAD_W    = 64,
    parameter int MAX_OUTSTANDING = 8,
    parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic [N_TARG_PORT-1:0]                   awvalid_i,
    input  logic [N_TARG_PORT-1:0][AW_PAYLOAD_W-1:0] awpayload_i,
    output logic [N_TARG_PORT-1:0]                   awready_o,
    output logic                                     awvalid_o,
    output logic [AW_PAYLOAD_W-1:0]                  awpayload_o,
    input  logic                                     awready_i,
    output logic                                     push_ID_o,
    output logic [LOG_N_TARG+N_TARG_PORT-1:0]        ID_o,
    input  logic                                     grant_FIFO_ID_i,
    input  logic                                     bvalid_i,
    input  logic                                     bready_i,
    output logic [CNT_W-1:0]                         outstanding_o
);

    typedef enum logic {
        ST_ARB    = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    localparam logic [LOG_N_TARG:0]   N_EXT    = (LOG_N_TARG+1)'(N_TARG_PORT);
    localparam logic [LOG_N_TARG-1:0] LAST_IDX = LOG_N_TARG'(N_TARG_PORT - 1);
    localparam logic [CNT_W-1:0]      MAX_CNT  = CNT_W'(MAX_OUTSTANDING);

    state_t                  r_state;
    logic [LOG_N_TARG-1:0]   r_rr;
    logic [LOG_N_TARG-1:0]   r_sel;
    logic [CNT_W-1:0]        r_cnt;

    logic [LOG_N_TARG-1:0]   w_winner;
    logic [LOG_N_TARG-1:0]   w_sel;
    logic [LOG_N_TARG-1:0]   w_sel_next;
    logic [N_TARG_PORT-1:0]  w_onehot;
    logic                    w_any;
    logic                    w_can_issue;
    logic                    w_hs;
    logic                    w_dec;

    // Round-robin search starting at r_rr. The index is kept one bit wider so
    // the wrap works for any port count, not only powers of two.
    always_comb begin
        logic [LOG_N_TARG:0] idx;
        logic                found;
        // NOTE: every combinational output gets a default before any branch,
        // otherwise a path that skips the assignment infers a latch.
        w_winner = r_rr;
        found    = 1'b0;
        for (int i = 0; i < N_TARG_PORT; i++) begin
            idx = {1'b0, r_rr} + (LOG_N_TARG+1)'(i);
            if (idx >= N_EXT) begin
                idx = idx - N_EXT;
            end
            if (!found && awvalid_i[idx[LOG_N_TARG-1:0]]) begin
                found    = 1'b1;
                w_winner = idx[LOG_N_TARG-1:0];
            end
        end
    end

    assign w_any       = |awvalid_i;
    assign w_can_issue = grant_FIFO_ID_i & (r_cnt < MAX_CNT) & w_any;

    // While LOCKED the FIFO and budget were already checked when awvalid_o
    // first rose; nothing else can consume them, so they are not re-checked.
    assign w_sel      = (r_state == ST_LOCKED) ? r_sel : (w_any ? w_winner : r_rr);
    assign awvalid_o  = (r_state == ST_LOCKED) ? 1'b1 : w_can_issue;
    assign w_hs       = awvalid_o & awready_i;
    assign w_sel_next = (w_sel == LAST_IDX) ? '0 : w_sel + 1'b1;

    always_comb begin
        w_onehot        = '0;
        w_onehot[w_sel] = 1'b1;
    end

    assign awready_o     = w_hs ? w_onehot : '0;
    assign push_ID_o     = w_hs;
    assign ID_o          = {w_sel, w_onehot};
    assign awpayload_o   = awpayload_i[w_sel];
    assign outstanding_o = r_cnt;

    // A B response with nothing outstanding is ignored so the count never
    // wraps below zero.
    assign w_dec = bvalid_i & bready_i & (r_cnt != '0);

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_ARB;
            r_rr    <= '0;
            r_sel   <= '0;
            r_cnt   <= '0;
        end else begin
            if (w_hs && !w_dec) begin
                r_cnt <= r_cnt + 1'b1;
            end else if (w_dec && !w_hs) begin
                r_cnt <= r_cnt - 1'b1;
            end

            case (r_state)
                ST_ARB: begin
                    if (w_hs) begin
                        r_rr <= w_sel_next;
                    end else if (awvalid_o) begin
                        r_sel   <= w_sel;
                        r_state <= ST_LOCKED;
                    end
                end
                ST_LOCKED: begin
                    if (awready_i) begin
                        r_rr    <= w_sel_next;
                        r_state <= ST_ARB;
                    end
                end
                default: r_state <= ST_ARB;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_aw_rr_scheduler.sv
module tb_axi_aw_rr_scheduler;

    localparam int N   = 7;
    localparam int LG  = 3;
    localparam int W   = 64;
    localparam int MAX = 8;
    localparam int CW  = 4;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [N-1:0]          awvalid_i;
    logic [N-1:0][W-1:0]   awpayload_i;
    logic [N-1:0]          awready_o;
    logic                  awvalid_o;
    logic [W-1:0]          awpayload_o;
    logic                  awready_i;
    logic                  push_ID_o;
    logic [LG+N-1:0]       ID_o;
    logic                  grant_FIFO_ID_i;
    logic                  bvalid_i;
    logic                  bready_i;
    logic [CW-1:0]         outstanding_o;

    axi_aw_rr_scheduler #(
        .N_TARG_PORT(N), .LOG_N_TARG(LG), .AW_PAYLOAD_W(W),
        .MAX_OUTSTANDING(MAX), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .awvalid_i(awvalid_i), .awpayload_i(awpayload_i), .awready_o(awready_o),
        .awvalid_o(awvalid_o), .awpayload_o(awpayload_o), .awready_i(awready_i),
        .push_ID_o(push_ID_o), .ID_o(ID_o), .grant_FIFO_ID_i(grant_FIFO_ID_i),
        .bvalid_i(bvalid_i), .bready_i(bready_i), .outstanding_o(outstanding_o)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: the scheduler as a priority pointer, an optional
    // pending (frozen) request index and a burst counter, all plain integers.
    bit m_ok   = 0;
    int m_rr   = 0;
    int m_pend = -1;
    int m_cnt  = 0;
    int m_sel;
    bit m_valid;
    bit m_hs;

    function automatic int rr_pick(input logic [N-1:0] req, input int start);
        for (int off = 0; off < N; off++) begin
            if (req[(start + off) % N]) return (start + off) % N;
        end
        return -1;
    endfunction

    task automatic predict_and_check();
        logic [N-1:0]    exp_rdy;
        logic [LG+N-1:0] exp_id;
        int              w;
        if (m_pend >= 0) begin
            m_valid = 1;
            m_sel   = m_pend;
        end else begin
            w       = rr_pick(awvalid_i, m_rr);
            m_valid = grant_FIFO_ID_i && (m_cnt < MAX) && (w >= 0);
            m_sel   = (w >= 0) ? w : m_rr;
        end
        m_hs    = m_valid && awready_i;
        exp_rdy = '0;
        if (m_hs) exp_rdy[m_sel] = 1'b1;
        exp_id           = '0;
        exp_id[LG+N-1:N] = LG'(m_sel);
        exp_id[m_sel]    = 1'b1;
        if (m_ok) begin
            check("awvalid", 64'(awvalid_o), 64'(m_valid));
            check("awready", 64'(awready_o), 64'(exp_rdy));
            check("push", 64'(push_ID_o), 64'(m_hs));
            check("outstanding", 64'(outstanding_o), 64'(m_cnt));
            if (m_valid) check("payload", awpayload_o, awpayload_i[m_sel]);
            if (m_hs) check("id", 64'(ID_o), 64'(exp_id));
        end
    endtask

    task automatic model_update();
        bit dec;
        if (!rst_n) begin
            m_ok = 1; m_rr = 0; m_pend = -1; m_cnt = 0;
        end else if (m_ok) begin
            dec = bvalid_i && bready_i && (m_cnt > 0);
            if (m_hs && !dec) m_cnt++;
            else if (dec && !m_hs) m_cnt--;
            if (m_hs) begin
                m_rr   = (m_sel + 1) % N;
                m_pend = -1;
            end else if (m_valid) begin
                m_pend = m_sel;
            end
        end
    endtask

    // Called just after a falling edge with inputs already driven.
    task automatic cycle();
        #1;
        predict_and_check();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic rand_payload();
        for (int p = 0; p < N; p++) awpayload_i[p] = {$urandom, $urandom};
    endtask

    task automatic drive(input logic [N-1:0] v, input logic rdy, input logic fifo, input logic b);
        awvalid_i       = v;
        awready_i       = rdy;
        grant_FIFO_ID_i = fifo;
        bvalid_i        = b;
        bready_i        = b;
    endtask

    initial begin
        rst_n = 1'b0;
        drive('0, 1'b0, 1'b1, 1'b0);
        rand_payload();
        @(negedge clk);
        cycle();
        cycle();
        rst_n = 1'b1;

        // Reset state.
        #1;
        check("rst_awvalid", 64'(awvalid_o), 64'd0);
        check("rst_awready", 64'(awready_o), 64'd0);
        check("rst_push", 64'(push_ID_o), 64'd0);
        check("rst_outstanding", 64'(outstanding_o), 64'd0);
        cycle();

        // Round-robin with all ports requesting; B every cycle keeps the
        // count low.
        drive('1, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 8; i++) begin
            rand_payload();
            #1;
            check("rr_order", 64'(awready_o), 64'(7'b1 << (i % N)));
            if (i == 3) check("rr_id3", 64'(ID_o), 64'({3'd3, 7'b0001000}));
            cycle();
        end

        // Stall/lock: ports 2 and 5, initiator not ready for 3 cycles.
        drive(7'b0100100, 1'b0, 1'b1, 1'b0);
        rand_payload();
        for (int i = 0; i < 3; i++) begin
            #1;
            check("lock_payload", awpayload_o, awpayload_i[2]);
            check("lock_valid", 64'(awvalid_o), 64'd1);
            cycle();
        end
        drive(7'b0100000, 1'b0, 1'b1, 1'b0);
        cycle();
        drive(7'b0100000, 1'b1, 1'b1, 1'b0);
        #1;
        check("lock_release", 64'(awready_o), 64'(7'b0000100));
        cycle();
        #1;
        check("after_lock", 64'(awready_o), 64'(7'b0100000));
        cycle();

        // FIFO backpressure.
        drive(7'b0000010, 1'b1, 1'b0, 1'b0);
        #1;
        check("fifo_block", 64'(awvalid_o), 64'd0);
        cycle();
        grant_FIFO_ID_i = 1'b1;
        #1;
        check("fifo_issue", 64'(awready_o), 64'(7'b0000010));
        cycle();

        // Drain outstanding bursts.
        drive('0, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 10; i++) cycle();

        // Wrap: port 6 granted, then 0 beats 6.
        drive(7'b1000000, 1'b1, 1'b1, 1'b0);
        cycle();
        drive(7'b1000001, 1'b1, 1'b1, 1'b0);
        #1;
        check("wrap_port0", 64'(awready_o), 64'(7'b0000001));
        cycle();

        // Outstanding cap.
        drive('1, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 12; i++) cycle();
        #1;
        check("cap_count", 64'(outstanding_o), 64'(MAX));
        check("cap_block", 64'(awvalid_o), 64'd0);
        bvalid_i = 1'b1; bready_i = 1'b1;
        cycle();
        bvalid_i = 1'b0; bready_i = 1'b0;
        #1;
        check("cap_freed", 64'(outstanding_o), 64'(MAX - 1));
        check("cap_issue", 64'(awvalid_o), 64'd1);
        cycle();
        bvalid_i = 1'b1; bready_i = 1'b1;
        cycle();
        cycle();
        bvalid_i = 1'b0; bready_i = 1'b0;
        #1;
        check("aw_and_b", 64'(outstanding_o), 64'(MAX - 1));
        cycle();

        // Reset while LOCKED.
        drive('0, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 10; i++) cycle();
        drive(7'b0010000, 1'b0, 1'b1, 1'b0);
        cycle();
        rst_n = 1'b0;
        #1;
        check("lockrst_nopush", 64'(push_ID_o), 64'd0);
        cycle();
        rst_n = 1'b1;
        drive('0, 1'b0, 1'b1, 1'b0);
        #1;
        check("lockrst_valid", 64'(awvalid_o), 64'd0);
        check("lockrst_count", 64'(outstanding_o), 64'd0);
        cycle();
        drive('1, 1'b1, 1'b1, 1'b0);
        #1;
        check("lockrst_rr0", 64'(awready_o), 64'(7'b0000001));
        cycle();

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            rst_n = ($urandom_range(0, 299) != 0);
            drive(N'($urandom) & N'($urandom | $urandom),
                  ($urandom_range(0, 9) < 7),
                  ($urandom_range(0, 9) < 8),
                  ($urandom_range(0, 9) < 4));
            rand_payload();
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
